// File: rtl/digital_clock_pkg.sv
// Shared types, limits and the load-field range check for the hh:mm:ss timekeeping core.
package digital_clock_pkg;

    localparam int unsigned HH_W = 5;
    localparam int unsigned MM_W = 6;
    localparam int unsigned SS_W = 6;

    localparam logic [SS_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MM_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic [1:0] {
        StStopped,
        StRunning,
        StLoad
    } clk_state_e;

    // Hours are 0..23 in 24 h mode and 1..12 in 12 h mode.
    function automatic logic fields_in_range(input int unsigned     hour_mode,
                                             input logic [HH_W-1:0] hh,
                                             input logic [MM_W-1:0] mm,
                                             input logic [SS_W-1:0] ss);
        logic hh_ok;
        if (hour_mode == 12) begin
            hh_ok = (hh >= 5'd1) && (hh <= 5'd12);
        end else begin
            hh_ok = (hh <= 5'd23);
        end
        return hh_ok && (mm <= MIN_MAX) && (ss <= SEC_MAX);
    endfunction

endpackage

// File: rtl/clock_prescaler.sv
// Divides the system clock down to one wrap pulse every TICK_DIV enabled cycles.
module clock_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    localparam int unsigned     CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] count_q, count_d;

    assign wrap = enable && (count_q == CntMax);

    always_comb begin
        count_d = count_q;
        if (clear || wrap) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/digital_clock_core.sv
// hh:mm:ss timekeeping core: 1 Hz prescaler, 24 h / 12 h counting, time-load handshake
// and a minute-resolution alarm.
module digital_clock_core
    import digital_clock_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned HOUR_MODE = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            set_valid,
    output logic            set_ready,
    input  logic [HH_W-1:0] set_hh,
    input  logic [MM_W-1:0] set_mm,
    input  logic [SS_W-1:0] set_ss,
    input  logic            set_pm,
    output logic            set_err,
    input  logic            alarm_en,
    input  logic [HH_W-1:0] alarm_hh,
    input  logic [MM_W-1:0] alarm_mm,
    input  logic            alarm_pm,
    input  logic            alarm_ack,
    output logic            alarm,
    output logic            tick_1hz,
    output logic [SS_W-1:0] seconds,
    output logic [MM_W-1:0] minutes,
    output logic [HH_W-1:0] hours,
    output logic            pm
);

    localparam logic             Mode12    = (HOUR_MODE == 12);
    localparam logic [HH_W-1:0] HourReset = Mode12 ? 5'd12 : 5'd0;

    clk_state_e      state_q, state_d;
    logic [SS_W-1:0] ss_q, ss_d;
    logic [MM_W-1:0] mm_q, mm_d;
    logic [HH_W-1:0] hh_q, hh_d, hh_inc;
    logic            pm_q, pm_d, pm_inc;
    logic            alarm_q, alarm_d;
    logic            tick_q, tick_d;
    logic            err_q, err_d;

    logic fields_ok, load_req, accept, prescale_en, wrap, advance, alarm_hit;

    assign set_ready   = (state_q != StLoad);
    assign fields_ok   = fields_in_range(HOUR_MODE, set_hh, set_mm, set_ss);
    assign load_req    = set_valid && set_ready;
    assign accept      = load_req && fields_ok;
    assign prescale_en = (state_q == StRunning);
    // A load in the same cycle as a wrap swallows that second.
    assign advance     = wrap && !accept;

    clock_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (reset),
        .enable (prescale_en),
        .clear  (accept),
        .wrap   (wrap)
    );

    always_comb begin
        state_d = run ? StRunning : StStopped;
        if (accept) begin
            state_d = StLoad;
        end
    end

    // 12 h: 11 -> 12 flips AM/PM, 12 -> 1 keeps it.
    always_comb begin
        hh_inc = hh_q + 5'd1;
        pm_inc = pm_q;
        if (Mode12) begin
            if (hh_q == 5'd12) begin
                hh_inc = 5'd1;
            end else if (hh_q == 5'd11) begin
                pm_inc = !pm_q;
            end
        end else if (hh_q == 5'd23) begin
            hh_inc = '0;
        end
    end

    always_comb begin
        ss_d = ss_q;
        mm_d = mm_q;
        hh_d = hh_q;
        pm_d = pm_q;
        if (accept) begin
            ss_d = set_ss;
            mm_d = set_mm;
            hh_d = set_hh;
            pm_d = Mode12 && set_pm;
        end else if (advance) begin
            if (ss_q == SEC_MAX) begin
                ss_d = '0;
                if (mm_q == MIN_MAX) begin
                    mm_d = '0;
                    hh_d = hh_inc;
                    pm_d = pm_inc;
                end else begin
                    mm_d = mm_q + 6'd1;
                end
            end else begin
                ss_d = ss_q + 6'd1;
            end
        end
    end

    assign alarm_hit = advance && (ss_d == '0) && (mm_d == alarm_mm) && (hh_d == alarm_hh)
                       && (!Mode12 || (pm_d == alarm_pm));

    always_comb begin
        alarm_d = alarm_q;
        if (!alarm_en) begin
            alarm_d = 1'b0;
        end else if (alarm_hit) begin
            alarm_d = 1'b1;
        end else if (alarm_ack) begin
            alarm_d = 1'b0;
        end
        tick_d = advance;
        err_d  = load_req && !fields_ok;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StStopped;
            ss_q    <= '0;
            mm_q    <= '0;
            hh_q    <= HourReset;
            pm_q    <= 1'b0;
            alarm_q <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ss_q    <= ss_d;
            mm_q    <= mm_d;
            hh_q    <= hh_d;
            pm_q    <= pm_d;
            alarm_q <= alarm_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    assign set_err  = err_q;
    assign alarm    = alarm_q;
    assign tick_1hz = tick_q;
    assign seconds  = ss_q;
    assign minutes  = mm_q;
    assign hours    = hh_q;
    assign pm       = pm_q;

endmodule

// File: tb/tb_digital_clock_core.sv
// Drives a 24 h and a 12 h core from shared stimulus and compares both against a
// seconds-of-day reference model every cycle.
module tb_digital_clock_core;

    localparam int unsigned TickDiv = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       run, set_valid, set_pm, alarm_en, alarm_pm, alarm_ack;
    logic [4:0] set_hh, alarm_hh;
    logic [5:0] set_mm, set_ss, alarm_mm;

    logic       ready24, err24, alarm24, tick24, pm24;
    logic [4:0] hours24;
    logic [5:0] minutes24, seconds24;
    logic       ready12, err12, alarm12, tick12, pm12;
    logic [4:0] hours12;
    logic [5:0] minutes12, seconds12;

    int n_vec = 0;
    int n_err = 0;

    // Reference state per instance (0: 24 h, 1: 12 h). st: 0 stopped, 1 running, 2 load.
    int st[2];
    int cnt[2];
    int tod[2];
    bit alm[2];
    bit tck[2];
    bit err[2];

    always #5 clk = !clk;

    digital_clock_core #(.TICK_DIV(TickDiv), .HOUR_MODE(24)) u_dut24 (
        .clk(clk), .reset(reset), .run(run), .set_valid(set_valid), .set_ready(ready24),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_pm(set_pm), .set_err(err24),
        .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_pm(alarm_pm),
        .alarm_ack(alarm_ack), .alarm(alarm24), .tick_1hz(tick24), .seconds(seconds24),
        .minutes(minutes24), .hours(hours24), .pm(pm24)
    );

    digital_clock_core #(.TICK_DIV(TickDiv), .HOUR_MODE(12)) u_dut12 (
        .clk(clk), .reset(reset), .run(run), .set_valid(set_valid), .set_ready(ready12),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_pm(set_pm), .set_err(err12),
        .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_pm(alarm_pm),
        .alarm_ack(alarm_ack), .alarm(alarm12), .tick_1hz(tick12), .seconds(seconds12),
        .minutes(minutes12), .hours(hours12), .pm(pm12)
    );

    function automatic bit model_fields_ok(input int m, input int hh, input int mm, input int ss);
        bit hh_ok = (m == 24) ? (hh <= 23) : (hh >= 1 && hh <= 12);
        return hh_ok && mm <= 59 && ss <= 59;
    endfunction

    // 12 h times map onto a 24 h day: 12 AM is hour 0, 12 PM is hour 12.
    function automatic int model_hour24(input int m, input int hh, input bit p);
        return (m == 24) ? hh : (hh % 12) + (p ? 12 : 0);
    endfunction

    function automatic bit model_alarm_hit(input int m, input int t);
        int ah = int'(alarm_hh);
        int am = int'(alarm_mm);
        if (am > 59) return 1'b0;
        if (m == 12 && (ah < 1 || ah > 12)) return 1'b0;
        if (m == 24 && ah > 23) return 1'b0;
        return (t % 60 == 0) && (t / 60 == model_hour24(m, ah, alarm_pm) * 60 + am);
    endfunction

    task automatic model_edge(input int i);
        int m = (i == 0) ? 24 : 12;
        bit req, ok, acc, adv;
        if (!reset) begin
            st[i] = 0; cnt[i] = 0; tod[i] = 0; alm[i] = 0; tck[i] = 0; err[i] = 0;
        end else begin
            req = set_valid && st[i] != 2;
            ok  = model_fields_ok(m, int'(set_hh), int'(set_mm), int'(set_ss));
            acc = req && ok;
            adv = 1'b0;
            if (st[i] == 1) begin
                if (cnt[i] == TickDiv - 1) begin
                    cnt[i] = 0;
                    adv    = !acc;
                end else begin
                    cnt[i]++;
                end
            end
            if (acc) begin
                tod[i] = model_hour24(m, int'(set_hh), set_pm) * 3600
                         + int'(set_mm) * 60 + int'(set_ss);
                cnt[i] = 0;
            end else if (adv) begin
                tod[i] = (tod[i] + 1) % 86400;
            end
            if (!alarm_en) alm[i] = 1'b0;
            else if (adv && model_alarm_hit(m, tod[i])) alm[i] = 1'b1;
            else if (alarm_ack) alm[i] = 1'b0;
            tck[i] = adv;
            err[i] = req && !ok;
            st[i]  = acc ? 2 : (run ? 1 : 0);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) model_edge(i);
    end

    function automatic logic [21:0] exp_vec(input int i);
        int h24 = tod[i] / 3600;
        int hh  = (i == 0) ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
        bit p   = (i == 1) && (h24 >= 12);
        return {st[i] != 2, err[i], alm[i], tck[i], 5'(hh), p, 6'((tod[i] / 60) % 60),
                6'(tod[i] % 60)};
    endfunction

    task automatic check_vec(input string tag, input logic [21:0] obs, input logic [21:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got rdy/err/alm/tick/hh/pm/mm/ss=%b/%b/%b/%b/%0d/%b/%0d/%0d want %b/%b/%b/%b/%0d/%b/%0d/%0d",
                     tag, $time, obs[21], obs[20], obs[19], obs[18], obs[17:13], obs[12],
                     obs[11:6], obs[5:0], exp[21], exp[20], exp[19], exp[18], exp[17:13],
                     exp[12], exp[11:6], exp[5:0]);
        end
    endtask

    task automatic check_all(input string tag);
        check_vec({tag, "_h24"}, {ready24, err24, alarm24, tick24, hours24, pm24, minutes24,
                                 seconds24}, exp_vec(0));
        check_vec({tag, "_h12"}, {ready12, err12, alarm12, tick12, hours12, pm12, minutes12,
                                 seconds12}, exp_vec(1));
    endtask

    task automatic step(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_all(tag);
        end
    endtask

    task automatic load(input string tag, input int hh, input bit p, input int mm, input int ss);
        set_hh    = 5'(hh);
        set_pm    = p;
        set_mm    = 6'(mm);
        set_ss    = 6'(ss);
        set_valid = 1'b1;
        step(tag, 1);
        set_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; run = 1'b1; set_valid = 1'b0; set_pm = 1'b0;
        set_hh = '0; set_mm = '0; set_ss = '0;
        alarm_en = 1'b0; alarm_hh = '0; alarm_mm = '0; alarm_pm = 1'b0; alarm_ack = 1'b0;

        step("reset", 3);
        reset = 1'b1;
        step("count", 14);

        load("ld_235959", 23, 0, 59, 59);
        step("wrap24", 8);
        load("ld_115959", 11, 0, 59, 59);
        step("noon", 8);
        load("ld_125959", 12, 1, 59, 59);
        step("one_pm", 8);
        load("ld_mm60", 5, 0, 60, 0);
        step("bad_load", 4);

        for (int k = 0; k < 8 && !(st[0] == 1 && cnt[0] == TickDiv - 1); k++) step("align", 1);
        load("ld_on_tick", 10, 1, 20, 30);
        step("after_ld", 6);

        alarm_en = 1'b1; alarm_hh = 5'd12; alarm_mm = 6'd1; alarm_pm = 1'b1;
        load("ld_alarm", 12, 1, 0, 58);
        step("alarm_rise", 12);
        alarm_ack = 1'b1;
        step("ack", 1);
        alarm_ack = 1'b0;
        step("acked", 2);
        load("ld_alarm2", 12, 1, 0, 58);
        for (int k = 0; k < 20 && !(st[0] == 1 && cnt[0] == TickDiv - 1 && tod[0] % 60 == 59);
             k++) step("align2", 1);
        alarm_ack = 1'b1;
        step("ack_match", 1);
        alarm_ack = 1'b0;
        step("held", 3);
        alarm_ack = 1'b1;
        step("ack_late", 1);
        alarm_ack = 1'b0;
        alarm_hh = 5'd0;
        load("ld_midnight", 0, 0, 0, 58);
        step("alarm24", 12);
        alarm_en = 1'b0;
        step("alarm_off", 2);

        run = 1'b0;
        step("frozen", 10);
        run = 1'b1;
        step("resume", 6);
        #2 reset = 1'b0;
        #1 check_all("async_rst");
        step("in_rst", 2);
        reset = 1'b1;
        step("post_rst", 6);

        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                alarm_hh = 5'($urandom_range(1, 12));
                alarm_mm = 6'd0;
            end
            run       = ($urandom_range(0, 9) != 0);
            set_valid = ($urandom_range(0, 7) == 0);
            set_hh    = 5'($urandom_range(0, 24));
            set_mm    = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 61)) : 6'd59;
            set_ss    = 6'($urandom_range(45, 60));
            set_pm    = 1'($urandom_range(0, 1));
            alarm_pm  = 1'($urandom_range(0, 1));
            alarm_en  = ($urandom_range(0, 31) != 0);
            alarm_ack = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b0;
                #1 check_all("rand_rst");
                step("rand_rst", 1);
                reset = 1'b1;
            end
            step("rand", 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
